// File: rtl/sine_tone_ctrl.sv
// sine_tone_ctrl: burst sequencer for the recursive sine generator.
// Holds a table of (cosW, sinW) coefficient pairs. Each burst issues one gen_load and
// then len paced gen_en strobes, one every div+1 cycles.
// Optional feature: define SINE_TONE_CTRL_CONT_EN to add the 'cont' input. With cont=1 a
// burst runs until abort or reset.
module sine_tone_ctrl #(
  parameter int unsigned WL    = 16,
  parameter int unsigned NTONE = 4,
  parameter int unsigned DIVW  = 8,
  parameter int unsigned LENW  = 12,
  parameter int unsigned AW    = $clog2(NTONE)
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [WL-1:0] cfg_cos,
  input  logic [WL-1:0] cfg_sin,
  input  logic          start,
`ifdef SINE_TONE_CTRL_CONT_EN
  input  logic          cont,
`endif
  input  logic [AW-1:0] tone_sel,
  input  logic [DIVW-1:0] div,
  input  logic [LENW-1:0] len,
  input  logic          abort,
  output logic          gen_load,
  output logic          gen_en,
  output logic [WL-1:0] gen_cosW,
  output logic [WL-1:0] gen_sinW,
  output logic          busy,
  output logic          done,
  output logic          sample_valid
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            cont_q, cont_d;
  logic [WL-1:0]   cos_q, cos_d;
  logic [WL-1:0]   sin_q, sin_d;
  logic            gen_load_q, gen_load_d;
  logic            gen_en_q, gen_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sample_valid_q, sample_valid_d;

  logic [WL-1:0] tbl_cos_q [NTONE];
  logic [WL-1:0] tbl_cos_d [NTONE];
  logic [WL-1:0] tbl_sin_q [NTONE];
  logic [WL-1:0] tbl_sin_d [NTONE];

  logic cont_in;
`ifdef SINE_TONE_CTRL_CONT_EN
  assign cont_in = cont;
`else
  assign cont_in = 1'b0;
`endif

  // Table write port; the start-time read sees the pre-write contents.
  always_comb begin
    tbl_cos_d = tbl_cos_q;
    tbl_sin_d = tbl_sin_q;
    if (cfg_we) begin
      tbl_cos_d[cfg_addr] = cfg_cos;
      tbl_sin_d[cfg_addr] = cfg_sin;
    end
  end

  // Table storage.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NTONE; i++) begin
        tbl_cos_q[i] <= '0;
        tbl_sin_q[i] <= '0;
      end
    end else begin
      tbl_cos_q <= tbl_cos_d;
      tbl_sin_q <= tbl_sin_d;
    end
  end

  // Next state, pacing counters and registered-output next values.
  // The en strobe is decided one cycle ahead: cnt_q==0 means gen_en is high next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    rem_d    = rem_q;
    cont_d   = cont_q;
    cos_d    = cos_q;
    sin_d    = sin_q;
    gen_en_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cos_d   = tbl_cos_q[tone_sel];
          sin_d   = tbl_sin_q[tone_sel];
          cnt_d   = div;
          div_d   = div;
          rem_d   = len;
          cont_d  = cont_in;
          state_d = StLoad;
        end
      end
      StLoad, StRun: begin
        if (state_q == StLoad && rem_q == '0 && !cont_q) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
          if (cnt_q == '0) begin
            gen_en_d = 1'b1;
            cnt_d    = div_q;
            if (!cont_q) begin
              rem_d = rem_q - 1'b1;
              // The final strobe is issued as the FSM enters DONE.
              if (rem_q == LENW'(1)) state_d = StDone;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort outranks both the pending strobe and any transition.
    if (abort && state_q != StIdle) begin
      state_d  = StIdle;
      gen_en_d = 1'b0;
    end

    gen_load_d     = (state_d == StLoad);
    busy_d         = (state_d == StLoad) || (state_d == StRun);
    done_d         = (state_q == StDone) && !abort;
    sample_valid_d = gen_en_q;
  end

  // FSM state, counters, latched burst parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      div_q          <= '0;
      rem_q          <= '0;
      cont_q         <= 1'b0;
      cos_q          <= '0;
      sin_q          <= '0;
      gen_load_q     <= 1'b0;
      gen_en_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      rem_q          <= rem_d;
      cont_q         <= cont_d;
      cos_q          <= cos_d;
      sin_q          <= sin_d;
      gen_load_q     <= gen_load_d;
      gen_en_q       <= gen_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign gen_load     = gen_load_q;
  assign gen_en       = gen_en_q;
  assign gen_cosW     = cos_q;
  assign gen_sinW     = sin_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_sine_tone_ctrl.sv
// Directed self-checking bench for sine_tone_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Offsets below count cycles after the gen_load cycle (offset 0).
module tb_sine_tone_ctrl;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_cos, cfg_sin;
  logic        start;
  logic        cont_tb;
  logic [1:0]  tone_sel;
  logic [7:0]  div;
  logic [11:0] len;
  logic        abort;
  logic        gen_load, gen_en, busy, done, sample_valid;
  logic [15:0] gen_cosW, gen_sinW;

  int n_vec  = 0;
  int n_miss = 0;

  // Burst trace statistics.
  int en_cnt, first_en, last_en, done_cnt, done_at, sv_cnt, first_sv, load_cnt, overlap, busy_off;

  sine_tone_ctrl dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_cos      (cfg_cos),
    .cfg_sin      (cfg_sin),
    .start        (start),
`ifdef SINE_TONE_CTRL_CONT_EN
    .cont         (cont_tb),
`endif
    .tone_sel     (tone_sel),
    .div          (div),
    .len          (len),
    .abort        (abort),
    .gen_load     (gen_load),
    .gen_en       (gen_en),
    .gen_cosW     (gen_cosW),
    .gen_sinW     (gen_sinW),
    .busy         (busy),
    .done         (done),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [15:0] c, input logic [15:0] s);
    cfg_we = 1'b1; cfg_addr = a; cfg_cos = c; cfg_sin = s;
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulse start; on return we sit in the load cycle, which is checked here.
  task automatic start_burst(input string tag, input logic [1:0] t, input logic [7:0] d,
                             input logic [11:0] l, input logic c,
                             input logic [15:0] exp_cos, input logic [15:0] exp_sin);
    start = 1'b1; tone_sel = t; div = d; len = l; cont_tb = c;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    check_eq({tag, ".load"}, gen_load, 1);
    check_eq({tag, ".load_en"}, gen_en, 0);
    check_eq({tag, ".load_busy"}, busy, 1);
    check_eq({tag, ".cos"}, gen_cosW, exp_cos);
    check_eq({tag, ".sin"}, gen_sinW, exp_sin);
  endtask

  // Trace ncyc cycles after load; optional abort and mid-burst config/start pokes.
  task automatic run_burst(input int ncyc, input int abort_at, input int mid_at);
    en_cnt = 0; first_en = -1; last_en = -1; done_cnt = 0; done_at = -1;
    sv_cnt = 0; first_sv = -1; load_cnt = 0; overlap = 0; busy_off = -1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      abort = 1'b0; cfg_we = 1'b0; start = 1'b0;
      if (gen_en) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (sample_valid) begin
        sv_cnt++;
        if (first_sv < 0) first_sv = k;
      end
      if (gen_load) load_cnt++;
      if (gen_load && gen_en) overlap++;
      if (!busy && busy_off < 0) busy_off = k;
      if (k == abort_at) abort = 1'b1;
      if (k == mid_at) begin
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_cos = 16'h5A82; cfg_sin = 16'h5A82;
        start = 1'b1; tone_sel = 2'd1;
      end
    end
  endtask

  initial begin
    reset_b = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_cos = '0; cfg_sin = '0;
    start = 1'b0; cont_tb = 1'b0; tone_sel = '0; div = '0; len = '0; abort = 1'b0;
    repeat (2) tick();
    check_eq("rst.outs", {gen_load, gen_en, busy, done, sample_valid}, 0);
    check_eq("rst.cos", gen_cosW, 0);
    reset_b = 1'b1;
    tick();

    // 1: div=3 len=5, strobes at 4,8,..,20, done at 21.
    write_entry(2'd2, 16'h7642, 16'h30FB);
    start_burst("t1", 2'd2, 8'd3, 12'd5, 1'b0, 16'h7642, 16'h30FB);
    run_burst(30, 0, 0);
    check_eq("t1.en_cnt", en_cnt, 5);
    check_eq("t1.first_en", first_en, 4);
    check_eq("t1.last_en", last_en, 20);
    check_eq("t1.done_at", done_at, 21);
    check_eq("t1.done_cnt", done_cnt, 1);
    check_eq("t1.reload", load_cnt, 0);
    check_eq("t1.overlap", overlap, 0);

    // 2: div=0 len=8, strobes at 1..8, valid at 2..9, done at 9.
    start_burst("t2", 2'd2, 8'd0, 12'd8, 1'b0, 16'h7642, 16'h30FB);
    run_burst(14, 0, 0);
    check_eq("t2.en_cnt", en_cnt, 8);
    check_eq("t2.first_en", first_en, 1);
    check_eq("t2.last_en", last_en, 8);
    check_eq("t2.sv_cnt", sv_cnt, 8);
    check_eq("t2.first_sv", first_sv, 2);
    check_eq("t2.done_at", done_at, 9);

    // 3: len=0, no strobes, done two cycles after load.
    start_burst("t3", 2'd2, 8'd2, 12'd0, 1'b0, 16'h7642, 16'h30FB);
    run_burst(8, 0, 0);
    check_eq("t3.en_cnt", en_cnt, 0);
    check_eq("t3.done_at", done_at, 2);

    // 4: abort on the 3rd strobe of len=10, then a fresh burst.
    start_burst("t4", 2'd2, 8'd0, 12'd10, 1'b0, 16'h7642, 16'h30FB);
    run_burst(12, 3, 0);
    check_eq("t4.en_cnt", en_cnt, 3);
    check_eq("t4.last_en", last_en, 3);
    check_eq("t4.busy_off", busy_off, 4);
    check_eq("t4.sv_cnt", sv_cnt, 3);
    check_eq("t4.done_cnt", done_cnt, 0);
    start_burst("t4r", 2'd2, 8'd0, 12'd2, 1'b0, 16'h7642, 16'h30FB);
    run_burst(6, 0, 0);
    check_eq("t4r.en_cnt", en_cnt, 2);
    check_eq("t4r.done_at", done_at, 3);

    // 5: rewrite active entry and pulse start mid-burst; both must not disturb it.
    start_burst("t5", 2'd2, 8'd1, 12'd6, 1'b0, 16'h7642, 16'h30FB);
    run_burst(16, 0, 3);
    check_eq("t5.en_cnt", en_cnt, 6);
    check_eq("t5.done_at", done_at, 13);
    check_eq("t5.reload", load_cnt, 0);
    check_eq("t5.cos_held", gen_cosW, 16'h7642);
    start_burst("t5n", 2'd2, 8'd0, 12'd0, 1'b0, 16'h5A82, 16'h5A82);
    run_burst(4, 0, 0);

    // Same-cycle write to the selected entry: start latches the old value.
    write_entry(2'd3, 16'h1111, 16'h2222);
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_cos = 16'h3333; cfg_sin = 16'h4444;
    start_burst("wr_old", 2'd3, 8'd0, 12'd0, 1'b0, 16'h1111, 16'h2222);
    run_burst(4, 0, 0);
    start_burst("wr_new", 2'd3, 8'd0, 12'd0, 1'b0, 16'h3333, 16'h4444);
    run_burst(4, 0, 0);

`ifdef SINE_TONE_CTRL_CONT_EN
    // 6: continuous mode, strobe every 2nd cycle until abort, no done.
    start_burst("t6", 2'd2, 8'd1, 12'd2, 1'b1, 16'h5A82, 16'h5A82);
    run_burst(125, 120, 0);
    check_eq("t6.en_cnt", en_cnt, 60);
    check_eq("t6.done_cnt", done_cnt, 0);
    check_eq("t6.busy_off", busy_off, 121);
`endif

    // Reset mid-burst: outputs clear without a clock edge, table cleared.
    start_burst("rm", 2'd2, 8'd0, 12'd20, 1'b0, 16'h5A82, 16'h5A82);
    run_burst(5, 0, 0);
    #1 reset_b = 1'b0;
    #1;
    check_eq("rm.outs", {gen_load, gen_en, busy, done, sample_valid}, 0);
    check_eq("rm.cos", gen_cosW, 0);
    #1 reset_b = 1'b1;
    tick();
    start_burst("rm.tbl", 2'd2, 8'd0, 12'd0, 1'b0, 16'h0000, 16'h0000);
    run_burst(4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
